// File: rtl/riscv_ctrl_pkg.sv
// Shared types and helpers for the pipeline control logic of the 5-stage core.
package riscv_ctrl_pkg;

    // Sequencer states. MD_BUSY covers the middle of a multi-cycle mul/div.
    // MD_DONE is the single cycle in which its result is valid in EX.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } ctrl_state_t;

    // x0 is hardwired to zero, so writing it never creates a dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

    // True when an ID-stage source operand is really read and names the given register.
    function automatic logic srcMatches(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Free-running event counter that wraps around when it overflows.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count one per cycle with inc high; overflow wraps back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core. It drives the PC enable and the
// hold/flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers, and it keeps
// counters of stall and flush events.
module pipeline_hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_is_muldiv,
    input  logic             ex_redirect,
    input  logic             icache_miss,
    input  logic             dcache_stall,
    output logic             pc_write_en,
    output logic             ifid_write_disable,
    output logic             ifid_flush,
    output logic             idex_write_disable,
    output logic             idex_flush,
    output logic             exmem_write_disable,
    output logic             exmem_flush,
    output logic             md_result_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // A mul/div holds EX for MD_LAT cycles, so MD_LAT-1 of them are stalls.
    // mdCnt_q counts the stall cycles already spent and never exceeds MD_LAT-2.
    localparam bit              MD_STALLS = (MD_LAT > 1);
    localparam int              MD_CW     = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [MD_CW-1:0] MD_LAST  = MD_CW'((MD_LAT > 2) ? (MD_LAT - 2) : 0);

    ctrl_state_t      state_q, state_d;
    logic [MD_CW-1:0] mdCnt_q, mdCnt_d;

    logic loadUseHazard;
    logic mdStall;
    logic flushEvent;
    logic stallInc;
    logic flushInc;

    // A load in EX feeds an ID operand: there is no forwarding path, so one bubble is needed.
    assign loadUseHazard = ex_mem_read && (ex_rd != REG_X0) &&
                           (srcMatches(id_uses_rs1, id_rs1, ex_rd) ||
                            srcMatches(id_uses_rs2, id_rs2, ex_rd));

    // A new mul/div arriving in RUN starts the stall. In MD_DONE, ex_is_muldiv is still
    // the op that is finishing, so it must not start another stall.
    assign mdStall = (ex_is_muldiv && (state_q == RUN) && MD_STALLS) || (state_q == MD_BUSY);

    // Resolve all hazard sources in strict priority order into the controls and the next state.
    always_comb begin
        pc_write_en         = 1'b1;
        ifid_write_disable  = 1'b0;
        ifid_flush          = 1'b0;
        idex_write_disable  = 1'b0;
        idex_flush          = 1'b0;
        exmem_write_disable = 1'b0;
        exmem_flush         = 1'b0;
        md_result_valid     = 1'b0;
        flushEvent          = 1'b0;
        state_d             = state_q;
        mdCnt_d             = mdCnt_q;

        if (reset) begin
            pc_write_en = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            state_d     = RUN;
            mdCnt_d     = '0;
        end else if (dcache_stall) begin
            pc_write_en         = 1'b0;
            ifid_write_disable  = 1'b1;
            idex_write_disable  = 1'b1;
            exmem_write_disable = 1'b1;
        end else if (mdStall) begin
            pc_write_en        = 1'b0;
            ifid_write_disable = 1'b1;
            idex_write_disable = 1'b1;
            exmem_flush        = 1'b1;
            if (state_q == RUN) begin
                if (MD_LAT == 2) begin
                    state_d = MD_DONE;
                end else begin
                    state_d = MD_BUSY;
                    mdCnt_d = MD_CW'(1);
                end
            end else if (mdCnt_q == MD_LAST) begin
                state_d = MD_DONE;
                mdCnt_d = '0;
            end else begin
                mdCnt_d = mdCnt_q + 1'b1;
            end
        end else begin
            if (state_q == MD_DONE) begin
                md_result_valid = 1'b1;
                state_d         = RUN;
            end
            if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                flushEvent = 1'b1;
            end else if (loadUseHazard) begin
                pc_write_en        = 1'b0;
                ifid_write_disable = 1'b1;
                idex_flush         = 1'b1;
            end else if (icache_miss) begin
                pc_write_en = 1'b0;
                ifid_flush  = 1'b1;
            end
        end
    end

    // Register the sequencer state and the count of mul/div stall cycles spent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            mdCnt_q <= '0;
        end else begin
            state_q <= state_d;
            mdCnt_q <= mdCnt_d;
        end
    end

    assign stallInc = !reset && !pc_write_en;
    assign flushInc = !reset && flushEvent;

    perf_counter #(.CNT_W(CNT_W)) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (stallInc),
        .count (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (flushInc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. It runs directed scenarios followed by random
// traffic. Every cycle is checked against a reference model of the priority rules.
// A second instance with 4-bit counters exercises counter wrap-around.
module tb_pipeline_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic        ex_mem_read, ex_is_muldiv, ex_redirect, icache_miss, dcache_stall;

    logic        pc_write_en, ifid_write_disable, ifid_flush, idex_write_disable, idex_flush;
    logic        exmem_write_disable, exmem_flush, md_result_valid;
    logic [31:0] stall_cnt, flush_cnt;

    logic        sPc, sIfidWd, sIfidFl, sIdexWd, sIdexFl, sExmemWd, sExmemFl, sMdv;
    logic [3:0]  sStallCnt, sFlushCnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: stall cycles spent on the current mul/div, and a flag for a result that is due.
    int          mStallsDone = 0;
    bit          mResultDue  = 1'b0;
    logic [31:0] mStall      = '0;
    logic [31:0] mFlush      = '0;
    int          nStallsDone;
    bit          nResultDue;
    logic [31:0] nStall, nFlush;
    logic [7:0]  expCtrl;

    pipeline_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_muldiv(ex_is_muldiv),
        .ex_redirect(ex_redirect), .icache_miss(icache_miss), .dcache_stall(dcache_stall),
        .pc_write_en(pc_write_en), .ifid_write_disable(ifid_write_disable), .ifid_flush(ifid_flush),
        .idex_write_disable(idex_write_disable), .idex_flush(idex_flush),
        .exmem_write_disable(exmem_write_disable), .exmem_flush(exmem_flush),
        .md_result_valid(md_result_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) u_small (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_muldiv(ex_is_muldiv),
        .ex_redirect(ex_redirect), .icache_miss(icache_miss), .dcache_stall(dcache_stall),
        .pc_write_en(sPc), .ifid_write_disable(sIfidWd), .ifid_flush(sIfidFl),
        .idex_write_disable(sIdexWd), .idex_flush(sIdexFl),
        .exmem_write_disable(sExmemWd), .exmem_flush(sExmemFl),
        .md_result_valid(sMdv), .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected controls, packed as {pc, ifidWd, ifidFl, idexWd, idexFl, exmemWd, exmemFl, mdValid}.
    task automatic modelCycle();
        bit loadUse;
        loadUse = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        nStallsDone = mStallsDone;
        nResultDue  = mResultDue;
        nStall      = mStall;
        nFlush      = mFlush;
        expCtrl     = 8'b1000_0000;
        if (reset) begin
            expCtrl     = 8'b0010_1000;
            nStallsDone = 0;
            nResultDue  = 1'b0;
            nStall      = '0;
            nFlush      = '0;
        end else if (dcache_stall) begin
            expCtrl = 8'b0101_0100;
        end else if (mStallsDone > 0 || (ex_is_muldiv && !mResultDue && MD_LAT > 1)) begin
            expCtrl     = 8'b0101_0010;
            nStallsDone = mStallsDone + 1;
            if (nStallsDone == MD_LAT - 1) begin
                nStallsDone = 0;
                nResultDue  = 1'b1;
            end
        end else begin
            expCtrl[0] = mResultDue;
            nResultDue = 1'b0;
            if (ex_redirect) begin
                expCtrl[5] = 1'b1;
                expCtrl[3] = 1'b1;
                nFlush     = mFlush + 1;
            end else if (loadUse) begin
                expCtrl[7] = 1'b0;
                expCtrl[6] = 1'b1;
                expCtrl[3] = 1'b1;
            end else if (icache_miss) begin
                expCtrl[7] = 1'b0;
                expCtrl[5] = 1'b1;
            end
        end
        if (!reset && !expCtrl[7]) begin
            nStall = nStall + 1;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".ctrl"}, {24'd0, pc_write_en, ifid_write_disable, ifid_flush,
                   idex_write_disable, idex_flush, exmem_write_disable, exmem_flush,
                   md_result_valid}, {24'd0, expCtrl});
        checkValue({tag, ".stall_cnt"}, stall_cnt, mStall);
        checkValue({tag, ".flush_cnt"}, flush_cnt, mFlush);
        checkValue({tag, ".small_stall_cnt"}, {28'd0, sStallCnt}, {28'd0, mStall[3:0]});
    endtask

    // Drive one cycle of inputs, check the same-cycle outputs, then advance the model past the edge.
    task automatic applyStimulus(input bit rst, input bit dc, input bit md, input bit rdr,
                                 input bit ic, input bit mr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input bit u1, input bit u2, input string tag);
        @(negedge clk);
        reset        = rst;
        dcache_stall = dc;
        ex_is_muldiv = md;
        ex_redirect  = rdr;
        icache_miss  = ic;
        ex_mem_read  = mr;
        ex_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        #1;
        modelCycle();
        checkOutput(tag);
        @(posedge clk);
        mStallsDone = nStallsDone;
        mResultDue  = nResultDue;
        mStall      = nStall;
        mFlush      = nFlush;
    endtask

    initial begin
        reset = 1'b1; dcache_stall = 1'b0; ex_is_muldiv = 1'b0; ex_redirect = 1'b0;
        icache_miss = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "reset0");
        applyStimulus(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "reset1");
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "idle");

        $display("[TB] load-use on rs2");
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 1, 1, "loaduse");
        checkValue("loaduse.ctrl_direct", {29'd0, pc_write_en, ifid_write_disable, idex_flush}, 32'd3);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5, 1, 1, "loaduse.after");
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, "loaduse_x0");

        $display("[TB] mul/div");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, (i < 4), 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, $sformatf("muldiv%0d", i));
        end
        #1;
        checkValue("muldiv.stall_total", stall_cnt, 32'd4);

        $display("[TB] mul/div with dcache stall");
        applyStimulus(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mddc0");
        applyStimulus(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mddc_freeze0");
        applyStimulus(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mddc_freeze1");
        applyStimulus(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mddc1");
        applyStimulus(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mddc2_redirect_held");
        applyStimulus(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mddc_done");
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mddc_run");

        $display("[TB] redirect beats load-use and icache miss");
        applyStimulus(0, 0, 0, 1, 1, 1, 5'd7, 5'd7, 5'd0, 1, 0, "redirect");
        #1;
        checkValue("redirect.flush_cnt", flush_cnt, 32'd1);

        $display("[TB] reset during MD_BUSY");
        applyStimulus(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mdrst0");
        applyStimulus(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mdrst1");
        applyStimulus(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mdrst_reset");
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mdrst_run");
        checkValue("mdrst.counters_zero", stall_cnt | flush_cnt, 32'd0);

        $display("[TB] counter wrap with 4-bit counters");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "wrap");
        end
        #1;
        checkValue("wrap17.small_stall_cnt", {28'd0, sStallCnt}, 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
